// File: rtl/fir_pkg.sv
// Shared definitions for the serial-MAC FIR family: FSM states and width helpers.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Smallest r such that 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Accumulator width that cannot overflow over taps products.
    function automatic int acc_width(input int in_w, input int coef_w, input int taps);
        return in_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp to a signed output width.
module fir_round_sat #(
    parameter int ACC_W = 19,
    parameter int OUT_W = 10,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    localparam int EW = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;

    logic signed [ACC_W:0]  rnd;
    logic signed [EW-1:0]   ext;
    logic signed [EW-1:0]   max_v;
    logic signed [EW-1:0]   min_v;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    if (SHIFT == 0) begin : g_noshift
        // Pass accumulator through sign-extended.
        always_comb begin
            rnd = (ACC_W + 1)'(acc);
        end
    end else begin : g_shift
        logic signed [ACC_W:0] wide;
        logic signed [ACC_W:0] half;
        // Add half an output LSB, then shift arithmetically.
        always_comb begin
            half          = '0;
            half[SHIFT-1] = 1'b1;
            wide          = (ACC_W + 1)'(acc);
            rnd           = (wide + half) >>> SHIFT;
        end
    end

    // Clamp to the representable output range and flag any clipping.
    always_comb begin
        ext              = EW'(rnd);
        max_v            = '0;
        max_v[OUT_W-2:0] = '1;
        min_v            = '1;
        min_v[OUT_W-2:0] = '0;
        sat              = 1'b0;
        y                = ext[OUT_W-1:0];
        if (ext > max_v) begin
            y   = max_v[OUT_W-1:0];
            sat = 1'b1;
        end else if (ext < min_v) begin
            y   = min_v[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// Single-multiplier time-multiplexed FIR with loadable coefficients.
module fir_serial_mac
    import fir_pkg::*;
#(
    parameter int   IN_W   = 8,
    parameter int   COEF_W = 8,
    parameter int   OUT_W  = 10,
    parameter int   TAPS   = 8,
    parameter int   SHIFT  = 0,
    localparam int  AW     = clog2(TAPS),
    localparam int  ACC_W  = acc_width(IN_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [IN_W-1:0]   x_in,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     y_valid,
    output logic                     sat_flag
);

    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    fir_state_t                     state;
    fir_state_t                     state_nxt;
    logic signed [IN_W-1:0]         d [TAPS];
    logic signed [COEF_W-1:0]       c [TAPS];
    logic signed [ACC_W-1:0]        acc;
    logic [AW-1:0]                  idx;
    logic signed [IN_W+COEF_W-1:0]  prod;
    logic signed [OUT_W-1:0]        y_rs;
    logic                           sat_rs;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        case (state)
            IDLE: begin
                x_ready = 1'b1;
                if (x_valid) state_nxt = MAC;
            end
            MAC:     if (idx == LAST) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single shared multiplier, selected by the tap index.
    always_comb begin
        prod = d[idx] * c[idx];
    end

    // Delay line, coefficient store, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                d[k] <= '0;
                c[k] <= '0;
            end
            acc      <= '0;
            idx      <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            y_valid  <= 1'b0;
            sat_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < TAPS)) c[coef_addr] <= coef_data;
                    if (x_valid) begin
                        d[0] <= x_in;
                        for (int unsigned k = 1; k < TAPS; k++) d[k] <= d[k-1];
                        acc <= '0;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + AW'(1);
                end
                OUT: begin
                    y_out    <= y_rs;
                    sat_flag <= sat_rs;
                    y_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc (acc),
        .y   (y_rs),
        .sat (sat_rs)
    );

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench: drivers push expected results, a negedge monitor pops and checks.
module tb_fir_serial_mac;

    localparam int TAPS = 8;

    typedef struct {
        int y;
        bit s;
        int t;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0][7:0]  x_in      = '0;
    logic [1:0]       x_valid   = '0;
    logic [1:0]       x_ready;
    logic [1:0]       coef_we   = '0;
    logic [1:0][2:0]  coef_addr = '0;
    logic [1:0][7:0]  coef_data = '0;
    logic [1:0][9:0]  y_out;
    logic [1:0]       y_valid;
    logic [1:0]       sat_flag;

    exp_t sb0[$];
    exp_t sb1[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    fir_serial_mac #(.SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .x_in(x_in[0]), .x_valid(x_valid[0]), .x_ready(x_ready[0]),
        .coef_we(coef_we[0]), .coef_addr(coef_addr[0]), .coef_data(coef_data[0]),
        .y_out(y_out[0]), .y_valid(y_valid[0]), .sat_flag(sat_flag[0])
    );

    fir_serial_mac #(.SHIFT(2)) u_dut1 (
        .clk(clk), .rst(rst), .x_in(x_in[1]), .x_valid(x_valid[1]), .x_ready(x_ready[1]),
        .coef_we(coef_we[1]), .coef_addr(coef_addr[1]), .coef_data(coef_data[1]),
        .y_out(y_out[1]), .y_valid(y_valid[1]), .sat_flag(sat_flag[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: every y_valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (y_valid[u]) begin
                exp_t e;
                int   got;
                if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_y_valid dut%0d got y=%0d exp=no output", u,
                             int'(signed'(y_out[u])));
                end else begin
                    e   = (u == 0) ? sb0.pop_front() : sb1.pop_front();
                    got = signed'(y_out[u]);
                    chk($sformatf("y_out dut%0d", u), got, e.y);
                    chk($sformatf("sat_flag dut%0d", u), int'(sat_flag[u]), int'(e.s));
                    chk($sformatf("latency dut%0d", u), cyc, e.t);
                end
            end
        end
    end

    // Called at a negedge; holds x_valid until accepted, records the accepting edge.
    task automatic send(input int u, input int x, input bit push, input int ey, input bit es,
                        output int acc_e);
        int   n;
        exp_t e;
        n            = 0;
        x_in[u]      = x[7:0];
        x_valid[u]   = 1'b1;
        while (!x_ready[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_wait dut%0d", u), int'(x_ready[u]), 1);
        acc_e = cyc + 1;
        if (push) begin
            e.y = ey;
            e.s = es;
            e.t = acc_e + TAPS + 1;
            if (u == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        x_valid[u] = 1'b0;
    endtask

    task automatic wcoef(input int u, input int a, input int v);
        coef_we[u]   = 1'b1;
        coef_addr[u] = a[2:0];
        coef_data[u] = v[7:0];
        @(negedge clk);
        coef_we[u]   = 1'b0;
    endtask

    task automatic load_std();
        int cs[8] = '{1, 2, 3, 4, 4, 3, 2, 1};
        for (int k = 0; k < 8; k++) wcoef(0, k, cs[k]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", sb0.size() + sb1.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int n;
        int imp[9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};

        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst y_out", int'(signed'(y_out[0])), 0);
        chk("rst y_valid", int'(y_valid[0]), 0);
        chk("rst sat_flag", int'(sat_flag[0]), 0);
        chk("rst x_ready", int'(x_ready[0]), 1);
        load_std();

        // Impulse, with busy-window length on the first sample
        send(0, 1, 1'b1, imp[0], 1'b0, a1);
        n = 0;
        while (!x_ready[0] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, TAPS + 1);
        for (int k = 1; k < 9; k++) send(0, 0, 1'b1, imp[k], 1'b0, a1);
        drain();

        // Negative impulse
        send(0, -1, 1'b1, -1, 1'b0, a1);
        for (int k = 1; k < 9; k++) send(0, 0, 1'b1, -imp[k], 1'b0, a1);
        drain();

        // Held step of 100: 100, 300, 600->511, 1000->511
        do_reset();
        load_std();
        send(0, 100, 1'b1, 100, 1'b0, a1);
        send(0, 100, 1'b1, 300, 1'b0, a1);
        send(0, 100, 1'b1, 511, 1'b1, a1);
        send(0, 100, 1'b1, 511, 1'b1, a1);
        drain();

        // Worst negative: -128*127*k always clips to -512
        do_reset();
        for (int k = 0; k < 8; k++) wcoef(0, k, 127);
        for (int k = 0; k < 8; k++) send(0, -128, 1'b1, -512, 1'b1, a1);
        drain();

        // Back-pressure: write while busy is ignored, held sample waits for IDLE
        do_reset();
        load_std();
        send(0, 1, 1'b1, 1, 1'b0, a1);
        wcoef(0, 1, 50);
        send(0, 0, 1'b1, 2, 1'b0, a2);
        chk("accept_spacing", a2 - a1, TAPS + 2);
        drain();

        // Mid-MAC reset: in-flight sample must vanish
        send(0, 1, 1'b0, 0, 1'b0, a1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst y_out", int'(signed'(y_out[0])), 0);
        chk("midrst x_ready", int'(x_ready[0]), 1);
        chk("midrst y_valid", int'(y_valid[0]), 0);
        repeat (15) @(negedge clk);
        send(0, 1, 1'b1, 0, 1'b0, a1);
        drain();
        // Delay line now holds only the post-reset impulse: expect c[1]=2
        load_std();
        send(0, 0, 1'b1, 2, 1'b0, a1);
        drain();

        // Rounding on the SHIFT=2 instance with c = 1,0,...
        wcoef(1, 0, 1);
        send(1, 3, 1'b1, 1, 1'b0, a1);
        send(1, -3, 1'b1, -1, 1'b0, a1);
        send(1, 2, 1'b1, 1, 1'b0, a1);
        send(1, -2, 1'b1, 0, 1'b0, a1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Parametrised, loadable-coefficient successor to the fixed hcub FIR.
- Single-multiplier, time-multiplexed direct-form FIR. Accepts one sample per valid/ready handshake and runs TAPS multiply-accumulate cycles.
- Emits a rounded, saturated result with a one-cycle valid strobe and a saturation flag.
- Sits between the sample source and downstream decimation/output logic.

Parameters:
- IN_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- OUT_W, 10, signed output width.
- TAPS, 8, number of taps (>=2).
- SHIFT, 0, arithmetic right shift applied before saturation (0..ACC_W-1).
- Derived localparams:
  - AW = clog2(TAPS)
  - ACC_W = IN_W+COEF_W+AW

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, synchronous active-low reset.
- x_in, in, IN_W, signed input sample.
- x_valid, in, 1, sample present.
- x_ready, out, 1, block can accept a sample/coef write (high only in IDLE).
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, AW, tap index.
- coef_data, in, COEF_W, signed coefficient value.
- y_out, out, OUT_W, signed filtered result; holds last value.
- y_valid, out, 1, one-cycle strobe, new y_out.
- sat_flag, out, 1, valid with y_valid; result was clipped.

Behaviour:
- Reset (rst=0 at an edge) clears:
  - delay line d[0..TAPS-1] and coefficients c[0..TAPS-1] to 0;
  - acc, index and state to IDLE;
  - y_out=0, y_valid=0, sat_flag=0.
  - x_ready=1 in the first cycle after reset.
- Reset overrides everything, including mid-MAC; the in-flight sample produces no y_valid.
- FSM has three states, IDLE, MAC and OUT:
  - IDLE: x_ready=1.
    - On x_valid: d shifts (d[k]<=d[k-1], d[0]<=x_in), acc<=0, idx<=0, go MAC.
    - Otherwise stay.
  - MAC: x_ready=0. acc<=acc+d[idx]*c[idx] (signed, full ACC_W), idx<=idx+1. When idx==TAPS-1, go OUT.
  - OUT: x_ready=0.
    - Registers y_out = sat(round(acc)) and sat_flag; y_valid=1 for exactly this one cycle.
    - Go IDLE.
- Latency: sample accepted at edge E; y_valid high in the cycle following edge E+TAPS+1.
- Throughput: one sample per TAPS+2 cycles.
- Round: SHIFT=0 uses acc unchanged; else (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up.
- Saturate: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat_flag=1 iff a clamp occurred.
- Coefficient writes take effect only when x_ready=1; coef_we while busy is ignored, with no queuing.
- Simultaneous coef_we and x_valid in IDLE: both performed; that sample's MAC uses the new coefficient.
- x_valid while busy: not accepted; the source must hold it until x_ready=1. The sample is consumed on the first IDLE edge.
- Accumulator cannot overflow by construction (ACC_W sizing).
- idx wraps only via the FSM exit; TAPS need not be a power of two.
- y_valid and sat_flag are 0 outside OUT.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding constants (IDLE/MAC/OUT);
  - clog2 function;
  - ACC_W derivation helper.
- One sub-module, fir_round_sat (combinational, params ACC_W/OUT_W/SHIFT): round, shift, clamp, sat flag. It is reused by future filters.

Test Plan (defaults unless noted; coefficients loaded as 1,2,3,4,4,3,2,1 first):
- Impulse: x=1 then zeros, 9 samples.
  -> y = 1,2,3,4,4,3,2,1,0; sat_flag=0.
  -> Each y_valid exactly TAPS+1 cycles after acceptance; x_ready low for 9 cycles per sample.
- Negative impulse: x=-1 then zeros.
  -> y = -1,-2,-3,-4,-4,-3,-2,-1,0.
- Step 100, held:
  -> y = 100,300,511,511...
  -> sat_flag 0,0,1,1...; unclipped third value is 600.
- Worst negative: all c=127, x=-128 for 8 samples.
  -> 8th y=-512 with sat_flag=1; internal acc=-130048.
- Rounding, SHIFT=2, c=1,0,...: x=3 -> y=1; x=-3 -> y=-1; x=2 -> y=1; x=-2 -> y=0.
- Back-pressure / mid-reset:
  - x_valid held through MAC -> second sample accepted only on the first IDLE edge.
  - coef_we during MAC -> coefficient unchanged.
  - rst=0 mid-MAC -> no y_valid; y_out=0, x_ready=1 next cycle; delay line cleared.
  - Next impulse gives y=0 (coefs cleared).
